// File: rtl/hsv_pkg.sv
// hsv_pkg -- shared types and constants for the hsv2rgb_pipe block.
//   sector_e   : hue sector index, values 0..5
//   sel_e      : which intermediate (v, p, q or t) drives an output channel
//   rgb_sel_t  : per-channel selection for one sector
//   sector_sel : sector -> (r,g,b) selection table
//   HSV2RGB_LATENCY : pipeline depth from input acceptance to out_valid
package hsv_pkg;

    localparam int HSV2RGB_LATENCY = 3;

    typedef enum logic [2:0] {
        SECT_0 = 3'd0,
        SECT_1 = 3'd1,
        SECT_2 = 3'd2,
        SECT_3 = 3'd3,
        SECT_4 = 3'd4,
        SECT_5 = 3'd5
    } sector_e;

    typedef enum logic [1:0] {
        SEL_V = 2'd0,
        SEL_P = 2'd1,
        SEL_Q = 2'd2,
        SEL_T = 2'd3
    } sel_e;

    typedef struct packed {
        sel_e r;
        sel_e g;
        sel_e b;
    } rgb_sel_t;

    // Codes 6 and 7 cannot occur (h*6 >> W never exceeds 5); they fall back to
    // sector 0 only so that the table is total.
    function automatic rgb_sel_t sector_sel(input sector_e sec);
        rgb_sel_t sel;
        case (sec)
            SECT_0:  sel = '{SEL_V, SEL_T, SEL_P};
            SECT_1:  sel = '{SEL_Q, SEL_V, SEL_P};
            SECT_2:  sel = '{SEL_P, SEL_V, SEL_T};
            SECT_3:  sel = '{SEL_P, SEL_Q, SEL_V};
            SECT_4:  sel = '{SEL_T, SEL_P, SEL_V};
            SECT_5:  sel = '{SEL_V, SEL_P, SEL_Q};
            default: sel = '{SEL_V, SEL_T, SEL_P};
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hsv2rgb_pipe_if.sv
// hsv2rgb_pipe_if -- pixel stream interface of hsv2rgb_pipe.
// Input side : in_valid, in_ready, h, s, v, in_tag (+ bypass when HSV2RGB_BYPASS_EN)
// Output side: out_valid, out_ready, r, g, b, out_tag
// Optional feature macro: HSV2RGB_BYPASS_EN adds the per-pixel bypass signal.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// The producer keeps valid and the payload stable until that transfer; ready
// may change freely and valid never depends on ready.
interface hsv2rgb_pipe_if #(
    parameter int W     = 8,
    parameter int TAG_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     h;
    logic [W-1:0]     s;
    logic [W-1:0]     v;
    logic [TAG_W-1:0] in_tag;
`ifdef HSV2RGB_BYPASS_EN
    logic             bypass;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     r;
    logic [W-1:0]     g;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] out_tag;

`ifdef HSV2RGB_BYPASS_EN
    modport master (output in_valid, h, s, v, in_tag, bypass, out_ready,
                    input  in_ready, out_valid, r, g, b, out_tag);
    modport slave  (input  in_valid, h, s, v, in_tag, bypass, out_ready,
                    output in_ready, out_valid, r, g, b, out_tag);
`else
    modport master (output in_valid, h, s, v, in_tag, out_ready,
                    input  in_ready, out_valid, r, g, b, out_tag);
    modport slave  (input  in_valid, h, s, v, in_tag, out_ready,
                    output in_ready, out_valid, r, g, b, out_tag);
`endif
endinterface

// File: rtl/hsv2rgb_pipe_umul_shr.sv
// umul_shr -- W x W unsigned multiply keeping only the upper W bits,
// i.e. y = floor(a * b / 2^W).
//   a_i, b_i : W-bit unsigned operands
//   y_o      : W-bit truncated product
module umul_shr #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    assign y_o  = W'(prod >> W);
endmodule

// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe -- three-stage HSV to RGB converter with valid/ready flow.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : hsv2rgb_pipe_if slave (h/s/v/in_tag in, r/g/b/out_tag out)
// S1: sector, f, v*s.  S2: s*f, s*(M-1-f), p.  S3: q, t, sector select.
// One global enable stalls every stage together while the output is blocked.
// Optional feature macro: HSV2RGB_BYPASS_EN (per-pixel pass-through of h,s,v).
module hsv2rgb_pipe
    import hsv_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 2
) (
    input logic           clk,
    input logic           rst,
    hsv2rgb_pipe_if.slave bus
);
    logic en;
    logic s1_valid_q, s2_valid_q, out_valid_q;

    // ---------------- Stage 1 ----------------
    logic [W+2:0]     h6;
    logic [W-1:0]     vs_w;
    sector_e          s1_sector_q;
    logic [W-1:0]     s1_f_q, s1_vs_q, s1_v_q, s1_s_q;
    logic [TAG_W-1:0] s1_tag_q;

    assign h6 = (W+3)'(bus.h) * (W+3)'(6);

    umul_shr #(.W(W)) u_vs (.a_i(bus.v), .b_i(bus.s), .y_o(vs_w));

    // ---------------- Stage 2 ----------------
    logic [W-1:0]     sf_w, sfn_w, p_w;
    sector_e          s2_sector_q;
    logic [W-1:0]     s2_v_q, s2_p_q, s2_sf_q, s2_sfn_q;
    logic [TAG_W-1:0] s2_tag_q;

    // M-1-f is simply the bitwise complement of f.
    umul_shr #(.W(W)) u_sf  (.a_i(s1_s_q), .b_i(s1_f_q),  .y_o(sf_w));
    umul_shr #(.W(W)) u_sfn (.a_i(s1_s_q), .b_i(~s1_f_q), .y_o(sfn_w));
    assign p_w = s1_v_q - s1_vs_q;

    // ---------------- Stage 3 ----------------
    logic [W-1:0]     vq_w, vt_w, q_w, t_w;
    rgb_sel_t         sel;
    logic [W-1:0]     r_d, g_d, b_d;
    logic [W-1:0]     r_q, g_q, b_q;
    logic [TAG_W-1:0] out_tag_q;

    umul_shr #(.W(W)) u_vq (.a_i(s2_v_q), .b_i(s2_sf_q),  .y_o(vq_w));
    umul_shr #(.W(W)) u_vt (.a_i(s2_v_q), .b_i(s2_sfn_q), .y_o(vt_w));
    assign q_w = s2_v_q - vq_w;
    assign t_w = s2_v_q - vt_w;

`ifdef HSV2RGB_BYPASS_EN
    logic         s1_bp_q, s2_bp_q;
    logic [W-1:0] s1_h_q, s2_h_q, s2_s_q;
`endif

    function automatic logic [W-1:0] pick(input sel_e sl, input logic [W-1:0] v,
                                          input logic [W-1:0] p, input logic [W-1:0] q,
                                          input logic [W-1:0] t);
        logic [W-1:0] y;
        case (sl)
            SEL_V:   y = v;
            SEL_P:   y = p;
            SEL_Q:   y = q;
            SEL_T:   y = t;
            default: y = v;
        endcase
        return y;
    endfunction

    always_comb begin
        sel = sector_sel(s2_sector_q);
        r_d = pick(sel.r, s2_v_q, s2_p_q, q_w, t_w);
        g_d = pick(sel.g, s2_v_q, s2_p_q, q_w, t_w);
        b_d = pick(sel.b, s2_v_q, s2_p_q, q_w, t_w);
`ifdef HSV2RGB_BYPASS_EN
        if (s2_bp_q) begin
            r_d = s2_h_q;
            g_d = s2_s_q;
            b_d = s2_v_q;
        end
`endif
    end

    // A stage may only move when the output register is free or being drained.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // Datapath stage registers: no reset, their content only matters under a valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_sector_q <= sector_e'(h6[W+2:W]);
            s1_f_q      <= h6[W-1:0];
            s1_vs_q     <= vs_w;
            s1_v_q      <= bus.v;
            s1_s_q      <= bus.s;
            s1_tag_q    <= bus.in_tag;
            s2_sector_q <= s1_sector_q;
            s2_v_q      <= s1_v_q;
            s2_p_q      <= p_w;
            s2_sf_q     <= sf_w;
            s2_sfn_q    <= sfn_w;
            s2_tag_q    <= s1_tag_q;
`ifdef HSV2RGB_BYPASS_EN
            s1_bp_q     <= bus.bypass;
            s1_h_q      <= bus.h;
            s2_bp_q     <= s1_bp_q;
            s2_h_q      <= s1_h_q;
            s2_s_q      <= s1_s_q;
`endif
        end
    end

    // Valid bits and visible outputs are reset; outputs only load real pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                r_q       <= r_d;
                g_q       <= g_d;
                b_q       <= b_d;
                out_tag_q <= s2_tag_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.g         = g_q;
    assign bus.b         = b_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_hsv2rgb_pipe.sv
module tb_hsv2rgb_pipe;
    import hsv_pkg::*;

    localparam int W     = 8;
    localparam int TAG_W = 2;
    localparam int OW    = 3*W + TAG_W;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   out_cnt  = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_v;
    bit            mon_bp;

    hsv2rgb_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

    hsv2rgb_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [OW-1:0] model(input int h, input int s, input int v,
                                            input int tag, input bit bp);
        int m, h6, sec, f, p, q, t, r, g, b;
        m   = 1 << W;
        h6  = h * 6;
        sec = h6 / m;
        f   = h6 % m;
        p   = v - (v * s) / m;
        q   = v - (v * ((s * f) / m)) / m;
        t   = v - (v * ((s * (m - 1 - f)) / m)) / m;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            5: begin r = v; g = p; b = q; end
            default: begin r = 0; g = 0; b = 0; end
        endcase
        if (bp) begin r = h; g = s; b = v; end
        return {W'(r), W'(g), W'(b), TAG_W'(tag)};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got r=%0d g=%0d b=%0d tag=%0d required no pixel",
                             bus.r, bus.g, bus.b, bus.out_tag);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({bus.r, bus.g, bus.b, bus.out_tag} !== exp_v) begin
                        failures++;
                        $display("FAIL scoreboard got r=%0d g=%0d b=%0d tag=%0d required r=%0d g=%0d b=%0d tag=%0d",
                                 bus.r, bus.g, bus.b, bus.out_tag,
                                 exp_v[OW-1 -: W], exp_v[OW-W-1 -: W], exp_v[OW-2*W-1 -: W],
                                 exp_v[TAG_W-1:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_bp = 1'b0;
`ifdef HSV2RGB_BYPASS_EN
                mon_bp = bus.bypass;
`endif
                exp_q.push_back(model(int'(bus.h), int'(bus.s), int'(bus.v),
                                      int'(bus.in_tag), mon_bp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.h         = '0;
        bus.s         = '0;
        bus.v         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
`ifdef HSV2RGB_BYPASS_EN
        bus.bypass    = 1'b0;
`endif
    endtask

    task automatic drive_pixel(input int h, input int s, input int v, input int tag, input bit bp);
        bus.in_valid = 1'b1;
        bus.h        = W'(h);
        bus.s        = W'(s);
        bus.v        = W'(v);
        bus.in_tag   = TAG_W'(tag);
`ifdef HSV2RGB_BYPASS_EN
        bus.bypass   = bp;
`endif
    endtask

    // Sends one pixel into an otherwise idle pipe and reports the cycles from the
    // acceptance edge (counted as 1) to the first cycle showing out_valid.
    task automatic send_one(input int h, input int s, input int v, input int tag, input bit bp,
                            output logic [3*W-1:0] rgb, output int lat);
        int n;
        lat = -1;
        rgb = 'x;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_pixel(h, s, v, tag, bp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                rgb = {bus.r, bus.g, bus.b};
                break;
            end
            @(posedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid);
        end
        checks++;
        if ({bus.r, bus.g, bus.b} !== '0) begin
            failures++; $display("FAIL reset_rgb got %0d,%0d,%0d required 0,0,0", bus.r, bus.g, bus.b);
        end
        checks++;
        if (bus.out_tag !== '0) begin
            failures++; $display("FAIL reset_tag got %0d required 0", bus.out_tag);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b required 1,0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_vectors();
        int th[4] = '{0, 14, 151, 255};
        int ts[4] = '{0, 153, 155, 255};
        int tv[4] = '{255, 100, 222, 255};
        logic [3*W-1:0] want[4];
        logic [3*W-1:0] rgb;
        int lat;
        want[0] = {8'd255, 8'd255, 8'd255};
        want[1] = {8'd100, 8'd61, 8'd41};
        want[2] = {8'd88, 8'd151, 8'd222};
        want[3] = {8'd255, 8'd1, 8'd7};
        for (int i = 0; i < 4; i++) begin
            send_one(th[i], ts[i], tv[i], i, 1'b0, rgb, lat);
            checks++;
            if (lat != HSV2RGB_LATENCY) begin
                failures++; $display("FAIL latency_vec%0d got %0d required %0d", i, lat, HSV2RGB_LATENCY);
            end
            checks++;
            if (rgb !== want[i]) begin
                failures++;
                $display("FAIL vector%0d got %0d,%0d,%0d required %0d,%0d,%0d", i,
                         rgb[23:16], rgb[15:8], rgb[7:0], want[i][23:16], want[i][15:8], want[i][7:0]);
            end
        end
    endtask

    task automatic test_grey();
        logic [3*W-1:0] rgb;
        int lat;
        for (int i = 0; i < 4; i++) begin
            int hh = $urandom_range(0, 255);
            int vv = $urandom_range(0, 255);
            send_one(hh, 0, vv, 3, 1'b0, rgb, lat);
            checks++;
            if (rgb !== {W'(vv), W'(vv), W'(vv)}) begin
                failures++;
                $display("FAIL grey h=%0d got %0d,%0d,%0d required %0d,%0d,%0d", hh,
                         rgb[23:16], rgb[15:8], rgb[7:0], vv, vv, vv);
            end
        end
    endtask

    task automatic test_random();
        int  sent = 0;
        bit  acc  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (sent >= 60 && exp_q.size() == 0) break;
            @(posedge clk); #1;
            if (!bus.in_valid || acc) begin
                if (sent < 60 && $urandom_range(0, 9) < 7)
                    drive_pixel($urandom_range(0, 255), $urandom_range(0, 255),
                                $urandom_range(0, 255), $urandom_range(0, 3),
                                1'($urandom_range(0, 1)));
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7) || (sent >= 60);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1;
        drive_idle();
        checks++;
        if (exp_q.size() != 0 || sent != 60) begin
            failures++;
            $display("FAIL random_drain got pending=%0d sent=%0d required pending=0 sent=60", exp_q.size(), sent);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int base = out_cnt;
        logic [OW-1:0] held;
        int ph[6], ps[6], pv[6];
        for (int i = 0; i < 6; i++) begin
            ph[i] = $urandom_range(0, 255);
            ps[i] = $urandom_range(0, 255);
            pv[i] = $urandom_range(0, 255);
        end
        held = '0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            bus.out_ready = (c < 2) || (c >= 12);
            if (sent < 6) drive_pixel(ph[sent], ps[sent], pv[sent], sent % 4, 1'b0);
            else          bus.in_valid = 1'b0;
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_backpressure got in_ready=%b out_valid=%b required 0,1",
                             bus.in_ready, bus.out_valid);
                end
                held = {bus.r, bus.g, bus.b, bus.out_tag};
            end
            if (c == 11) begin
                checks++;
                if ({bus.r, bus.g, bus.b, bus.out_tag} !== held || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold got %h valid=%b required %h valid=1",
                             {bus.r, bus.g, bus.b, bus.out_tag}, bus.out_valid, held);
                end
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (c >= 12 && sent == 6 && exp_q.size() == 0) break;
        end
        checks++;
        if (out_cnt - base != 6) begin
            failures++; $display("FAIL stall_count got %0d required 6", out_cnt - base);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        logic [3*W-1:0] rgb;
        logic [OW-1:0]  want;
        int lat;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_pixel(14, 153, 100, 1, 1'b0);
        @(posedge clk); #1;
        drive_pixel(151, 155, 222, 2, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || {bus.r, bus.g, bus.b, bus.out_tag} !== '0) begin
            failures++;
            $display("FAIL midreset_clear got valid=%b rgbt=%h required 0,0", bus.out_valid,
                     {bus.r, bus.g, bus.b, bus.out_tag});
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_in_ready got %b required 1", bus.in_ready);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midreset_ghost got %0d valid cycles required 0", seen);
        end
        send_one(200, 90, 180, 3, 1'b0, rgb, lat);
        want = model(200, 90, 180, 3, 1'b0);
        checks++;
        if (lat != HSV2RGB_LATENCY || rgb !== want[OW-1:TAG_W]) begin
            failures++;
            $display("FAIL midreset_new got lat=%0d rgb=%h required lat=%0d rgb=%h", lat, rgb,
                     HSV2RGB_LATENCY, want[OW-1:TAG_W]);
        end
    endtask

`ifdef HSV2RGB_BYPASS_EN
    task automatic test_bypass();
        int sent = 0;
        int got  = 0;
        logic [3*W-1:0] want;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            if (sent < 6) drive_pixel(14, 153, 100, sent % 4, (sent % 2) == 0);
            else          bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                want = (got % 2 == 0) ? {8'd14, 8'd153, 8'd100} : {8'd100, 8'd61, 8'd41};
                checks++;
                if ({bus.r, bus.g, bus.b} !== want) begin
                    failures++;
                    $display("FAIL bypass%0d got %0d,%0d,%0d required %0d,%0d,%0d", got,
                             bus.r, bus.g, bus.b, want[23:16], want[15:8], want[7:0]);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            if (got == 6) break;
        end
        checks++;
        if (got != 6) begin
            failures++; $display("FAIL bypass_count got %0d required 6", got);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        test_reset();
        test_vectors();
        test_grey();
        test_random();
        test_stall();
        test_reset_midstream();
`ifdef HSV2RGB_BYPASS_EN
        test_bypass();
`endif
        repeat (6) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL final_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
